// File: rtl/inst_encoder.sv
// LoongArch instruction encoder: range-checks field-level requests and packs
// legal ones into 32-bit words tagged with sequential word addresses.
module inst_encoder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rj,
  input  logic [4:0]        in_rk,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [5:0]        err_kind
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    F_BAD, F_3R, F_SHI, F_SI12, F_UI12, F_RI20, F_RI16, F_I26
  } fmt_t;

  fmt_t        fmt;
  logic [5:0]  op6;
  logic [3:0]  op4;
  logic [4:0]  f5;
  logic [31:0] word;
  logic        legal;
  logic        si12_ok, ui12_ok, ui5_ok, si20_ok, off16_ok, off26_ok;
  logic [25:0] off26;
  logic        accept, drain;
  logic [ADDR_W:0] count_nxt;

  // Format and opcode selection; numbering follows the decoder's kind order.
  always_comb begin
    fmt = F_BAD;
    op6 = 6'h00;
    op4 = 4'h0;
    f5  = 5'h00;
    case (in_kind)
      6'd0:  begin fmt = F_3R;   f5 = 5'h00; end
      6'd1:  begin fmt = F_SI12; op4 = 4'ha; end
      6'd2:  begin fmt = F_RI20; op6 = 6'h05; end
      6'd3:  begin fmt = F_3R;   f5 = 5'h02; end
      6'd4:  begin fmt = F_RI20; op6 = 6'h07; end
      6'd5:  begin fmt = F_3R;   f5 = 5'h04; end
      6'd6:  begin fmt = F_3R;   f5 = 5'h05; end
      6'd7:  begin fmt = F_SI12; op4 = 4'h8; end
      6'd8:  begin fmt = F_SI12; op4 = 4'h9; end
      6'd9:  begin fmt = F_3R;   f5 = 5'h09; end
      6'd10: begin fmt = F_3R;   f5 = 5'h0a; end
      6'd11: begin fmt = F_3R;   f5 = 5'h08; end
      6'd12: begin fmt = F_3R;   f5 = 5'h0b; end
      6'd13: begin fmt = F_UI12; op4 = 4'hd; end
      6'd14: begin fmt = F_UI12; op4 = 4'he; end
      6'd15: begin fmt = F_UI12; op4 = 4'hf; end
      6'd16: begin fmt = F_SHI;  f5 = 5'h01; end
      6'd17: begin fmt = F_SHI;  f5 = 5'h09; end
      6'd18: begin fmt = F_SHI;  f5 = 5'h11; end
      6'd19: begin fmt = F_3R;   f5 = 5'h0e; end
      6'd20: begin fmt = F_3R;   f5 = 5'h0f; end
      6'd21: begin fmt = F_3R;   f5 = 5'h10; end
      6'd22: begin fmt = F_SI12; op6 = 6'h0a; op4 = 4'h2; end
      6'd23: begin fmt = F_SI12; op6 = 6'h0a; op4 = 4'h1; end
      6'd24: begin fmt = F_SI12; op6 = 6'h0a; op4 = 4'h0; end
      6'd25: begin fmt = F_SI12; op6 = 6'h0a; op4 = 4'h9; end
      6'd26: begin fmt = F_SI12; op6 = 6'h0a; op4 = 4'h8; end
      6'd27: begin fmt = F_SI12; op6 = 6'h0a; op4 = 4'h6; end
      6'd28: begin fmt = F_SI12; op6 = 6'h0a; op4 = 4'h5; end
      6'd29: begin fmt = F_SI12; op6 = 6'h0a; op4 = 4'h4; end
      6'd30: begin fmt = F_RI16; op6 = 6'h13; end
      6'd31: begin fmt = F_I26;  op6 = 6'h15; end
      6'd32: begin fmt = F_I26;  op6 = 6'h14; end
      6'd33: begin fmt = F_RI16; op6 = 6'h16; end
      6'd34: begin fmt = F_RI16; op6 = 6'h17; end
      6'd35: begin fmt = F_RI16; op6 = 6'h18; end
      6'd36: begin fmt = F_RI16; op6 = 6'h1a; end
      6'd37: begin fmt = F_RI16; op6 = 6'h19; end
      6'd38: begin fmt = F_RI16; op6 = 6'h1b; end
      default: fmt = F_BAD;
    endcase
  end

  // Immediate legality: upper bits must be a pure sign (or zero) extension.
  always_comb begin
    si12_ok  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    ui12_ok  = ~(|in_imm[31:12]);
    ui5_ok   = ~(|in_imm[31:5]);
    si20_ok  = (&in_imm[31:19]) | ~(|in_imm[31:19]);
    off16_ok = ~(|in_imm[1:0]) & ((&in_imm[31:17]) | ~(|in_imm[31:17]));
    off26_ok = ~(|in_imm[1:0]) & ((&in_imm[31:27]) | ~(|in_imm[31:27]));
    off26    = in_imm[27:2];
  end

  // Word assembly per format.
  always_comb begin
    word  = 32'h0;
    legal = 1'b0;
    case (fmt)
      F_3R: begin
        word  = {6'h00, 4'h0, 2'h1, f5, in_rk, in_rj, in_rd};
        legal = 1'b1;
      end
      F_SHI: begin
        word  = {6'h00, 4'h1, 2'h0, f5, in_imm[4:0], in_rj, in_rd};
        legal = ui5_ok;
      end
      F_SI12: begin
        word  = {op6, op4, in_imm[11:0], in_rj, in_rd};
        legal = si12_ok;
      end
      F_UI12: begin
        word  = {op6, op4, in_imm[11:0], in_rj, in_rd};
        legal = ui12_ok;
      end
      F_RI20: begin
        word  = {op6, 1'b0, in_imm[19:0], in_rd};
        legal = si20_ok;
      end
      F_RI16: begin
        word  = {op6, in_imm[17:2], in_rj, in_rd};
        legal = off16_ok;
      end
      F_I26: begin
        word  = {op6, off26[15:0], off26[25:16]};
        legal = off26_ok;
      end
      default: begin
        word  = 32'h0;
        legal = 1'b0;
      end
    endcase
  end

  assign in_ready  = ~start & ~full & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign count_nxt = count + CNT_W'(1);

  // Single output stage with pass-through ready; start clears bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_inst  <= 32'h0;
      out_addr  <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      err_kind  <= 6'h0;
    end else if (start) begin
      out_valid <= 1'b0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      err_kind  <= 6'h0;
    end else begin
      if (accept && legal) begin
        out_valid <= 1'b1;
        out_inst  <= word;
        out_addr  <= count[ADDR_W-1:0];
        count     <= count_nxt;
        full      <= (count_nxt == DEPTH);
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (accept && !legal) begin
        err <= 1'b1;
        if (!err) err_kind <= in_kind;
      end
    end
  end

endmodule
